// File: rtl/t_chain_pkg.sv
// Shared types and constants for the forward-kinematics chain multiplier.
// Optional build macro: T_CHAIN_MULT_SATURATE_EN (see mat_dot4).
package t_chain_pkg;

  localparam int WIDTH      = 27;
  localparam int FRAC       = 8;
  localparam int ONE        = 256;
  localparam int MAX_JOINTS = 8;

  typedef logic signed [WIDTH-1:0] elem_t;
  typedef elem_t [3:0][3:0]        mat4_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_T = 3'd1,
    MULT   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic mat4_t identity_mat();
    mat4_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = elem_t'(ONE);
    return m;
  endfunction

endpackage

// File: rtl/t_chain_mult_mat_dot4.sv
// Combinational 4-term fixed-point dot product with floor shift and narrowing.
// T_CHAIN_MULT_SATURATE_EN selects clamping (with overflow bit); otherwise wraps.
module mat_dot4
  import t_chain_pkg::*;
(
  input  logic [3:0][WIDTH-1:0] a,
  input  logic [3:0][WIDTH-1:0] b,
  output logic [WIDTH-1:0]      y,
  output logic                  ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 2;

  logic signed [PW-1:0] prod [4];
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  for (genvar gi = 0; gi < 4; gi++) begin : g_prod
    assign prod[gi] = PW'($signed(a[gi])) * PW'($signed(b[gi]));
  end

  assign sum     = SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]) + SW'(prod[3]);
  assign shifted = sum >>> FRAC;

`ifdef T_CHAIN_MULT_SATURATE_EN
  localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (WIDTH - 1)));

  always_comb begin
    y   = WIDTH'(shifted);
    ovf = 1'b0;
    if (shifted > MAX_V) begin
      y   = WIDTH'(MAX_V);
      ovf = 1'b1;
    end else if (shifted < MIN_V) begin
      y   = WIDTH'(MIN_V);
      ovf = 1'b1;
    end
  end
`else
  assign y   = WIDTH'(shifted);
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/t_chain_mult.sv
// Accumulates T_total = T_1 * ... * T_N, one output element per cycle.
// Build macro T_CHAIN_MULT_SATURATE_EN enables saturation and the sticky ovf flag.
module t_chain_mult
  import t_chain_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [3:0]                    num_joints,
  input  logic                          t_valid,
  output logic                          t_ready,
  input  logic [3:0][3:0][WIDTH-1:0]    t_matrix,
  output logic [3:0][3:0][WIDTH-1:0]    result,
  output logic                          done,
  output logic                          busy,
  output logic                          ovf
);

  localparam logic [3:0] MAX_N = 4'(MAX_JOINTS);

  state_t     state_reg;
  mat4_t      acc_reg, nxt_reg, t_reg, result_reg;
  logic [3:0] idx_reg, jcnt_reg, n_reg;
  logic       done_reg, ovf_reg;

  logic [1:0]             row, col;
  logic [3:0]             n_clamp;
  logic [3:0][WIDTH-1:0]  acc_row, t_col;
  logic [WIDTH-1:0]       dot_y;
  logic                   dot_ovf;

  assign row     = idx_reg[3:2];
  assign col     = idx_reg[1:0];
  assign n_clamp = (num_joints > MAX_N) ? MAX_N : num_joints;

  // Row of acc against column of the latched joint transform.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sel
    assign acc_row[gi] = acc_reg[row][gi];
    assign t_col[gi]   = t_reg[gi][col];
  end

  mat_dot4 u_dot (
    .a   (acc_row),
    .b   (t_col),
    .y   (dot_y),
    .ovf (dot_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      nxt_reg    <= '0;
      t_reg      <= '0;
      result_reg <= '0;
      idx_reg    <= '0;
      jcnt_reg   <= '0;
      n_reg      <= '0;
      done_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg   <= identity_mat();
            jcnt_reg  <= '0;
            n_reg     <= n_clamp;
            ovf_reg   <= 1'b0;
            state_reg <= (n_clamp == 4'd0) ? DONE : WAIT_T;
          end
        end
        WAIT_T: begin
          if (t_valid) begin
            t_reg     <= t_matrix;
            idx_reg   <= '0;
            state_reg <= MULT;
          end
        end
        MULT: begin
          nxt_reg[row][col] <= dot_y;
          ovf_reg           <= ovf_reg | dot_ovf;
          idx_reg           <= idx_reg + 4'd1;
          if (idx_reg == 4'd15) state_reg <= COMMIT;
        end
        COMMIT: begin
          acc_reg   <= nxt_reg;
          jcnt_reg  <= jcnt_reg + 4'd1;
          state_reg <= ((jcnt_reg + 4'd1) == n_reg) ? DONE : WAIT_T;
        end
        DONE: begin
          result_reg <= acc_reg;
          done_reg   <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign t_ready = (state_reg == WAIT_T);
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign ovf     = ovf_reg;
  assign result  = result_reg;

endmodule
